// File: rtl/coproc_pkg.sv
// Shared types for the coprocessor result path: default widths and the buffered result entry.
package coproc_pkg;

    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned RD_WIDTH   = 5;
    localparam int unsigned DATA_WIDTH = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [RD_WIDTH-1:0]   rd;
        logic                  we;
        logic [DATA_WIDTH-1:0] data;
        logic                  killed;
    } result_entry_t;

endpackage

// File: rtl/xif_result_buffer.sv
// In-order result FIFO towards the eXtension-interface result channel, with
// show-ahead head presentation and in-place kill marking from the commit channel.
module xif_result_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = coproc_pkg::X_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = coproc_pkg::DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [X_ID_WIDTH-1:0]    push_id_i,
    input  logic [4:0]               push_rd_i,
    input  logic                     push_we_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o,
    output logic                     result_we_o,
    output logic [DATA_WIDTH-1:0]    result_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     full_o
);

    import coproc_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    result_entry_t   mem_q [DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [PW-1:0]   level;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [AW-1:0]   offs [DEPTH];
    logic [DEPTH-1:0] occupied;
    result_entry_t   head;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            kill;

    // Occupancy and handshake decode; a killed head is discarded without a handshake.
    always_comb begin
        level    = wptr_q - rptr_q;
        empty    = (level == '0);
        full     = (level == PW'(DEPTH));
        raddr    = rptr_q[AW-1:0];
        waddr    = wptr_q[AW-1:0];
        head     = mem_q[raddr];
        kill     = commit_valid_i && commit_kill_i;
        push     = push_valid_i && !full;
        pop      = !empty && (head.killed || result_ready_i);
        occupied = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs[i]     = AW'(i) - raddr;
            occupied[i] = (PW'(offs[i]) < level);
        end
    end

    // Head presentation; fields are zeroed whenever no valid result is offered.
    always_comb begin
        result_valid_o = !empty && !head.killed;
        result_id_o    = '0;
        result_rd_o    = '0;
        result_we_o    = 1'b0;
        result_data_o  = '0;
        if (result_valid_o) begin
            result_id_o   = head.id;
            result_rd_o   = head.rd;
            result_we_o   = head.we;
            result_data_o = head.data;
        end
        push_ready_o = !full;
        level_o      = level;
        empty_o      = empty;
        full_o       = full;
    end

    // Pointers and storage; a same-cycle push overrides any kill marking of its slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill && occupied[i] && (mem_q[i].id == commit_id_i)) begin
                    mem_q[i].killed <= 1'b1;
                end
            end
            if (push) begin
                mem_q[waddr] <= '{id:     push_id_i,
                                  rd:     push_rd_i,
                                  we:     push_we_i,
                                  data:   push_data_i,
                                  killed: kill && (push_id_i == commit_id_i)};
            end
        end
    end

endmodule

// File: tb/tb_xif_result_buffer.sv
// Bench for xif_result_buffer: directed vector table, async reset sequence and
// randomized traffic, all checked against a queue-based reference model.
module tb_xif_result_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDW   = 4;
    localparam int unsigned DW    = 32;

    logic           clk;
    logic           rst_n;
    logic           push_valid;
    logic           push_ready_o;
    logic [IDW-1:0] push_id;
    logic [4:0]     push_rd;
    logic           push_we;
    logic [DW-1:0]  push_data;
    logic           commit_valid;
    logic [IDW-1:0] commit_id;
    logic           commit_kill;
    logic           result_valid_o;
    logic           result_ready;
    logic [IDW-1:0] result_id_o;
    logic [4:0]     result_rd_o;
    logic           result_we_o;
    logic [DW-1:0]  result_data_o;
    logic [2:0]     level_o;
    logic           empty_o;
    logic           full_o;

    xif_result_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .push_valid_i   (push_valid),
        .push_ready_o   (push_ready_o),
        .push_id_i      (push_id),
        .push_rd_i      (push_rd),
        .push_we_i      (push_we),
        .push_data_i    (push_data),
        .commit_valid_i (commit_valid),
        .commit_id_i    (commit_id),
        .commit_kill_i  (commit_kill),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready),
        .result_id_o    (result_id_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .result_data_o  (result_data_o),
        .level_o        (level_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [4:0]     rd;
        logic           we;
        logic [DW-1:0]  data;
        bit             killed;
    } ent_t;

    typedef struct {
        bit             pv;
        logic [IDW-1:0] id;
        logic [4:0]     rd;
        logic [DW-1:0]  data;
        bit             cv;
        bit             ck;
        logic [IDW-1:0] cid;
        bit             rdy;
        bit             ev;
        logic [IDW-1:0] eid;
        int             el;
        bit             ef;
    } vec_t;

    ent_t mq[$];
    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare every output against the reference queue.
    task automatic check_model(input string tag);
        bit ev;
        ev = (mq.size() > 0) && !mq[0].killed;
        chk({tag, " valid"}, 64'(result_valid_o), 64'(ev));
        chk({tag, " level"}, 64'(level_o), 64'(mq.size()));
        chk({tag, " empty"}, 64'(empty_o), 64'(mq.size() == 0));
        chk({tag, " full"}, 64'(full_o), 64'(mq.size() == DEPTH));
        chk({tag, " push_ready"}, 64'(push_ready_o), 64'(mq.size() != DEPTH));
        chk({tag, " id"}, 64'(result_id_o), ev ? 64'(mq[0].id) : 64'd0);
        chk({tag, " rd"}, 64'(result_rd_o), ev ? 64'(mq[0].rd) : 64'd0);
        chk({tag, " we"}, 64'(result_we_o), ev ? 64'(mq[0].we) : 64'd0);
        chk({tag, " data"}, 64'(result_data_o), ev ? 64'(mq[0].data) : 64'd0);
    endtask

    task automatic drive(input bit pv, input logic [IDW-1:0] id, input logic [4:0] rd,
                         input bit we, input logic [DW-1:0] data, input bit cv, input bit ck,
                         input logic [IDW-1:0] cid, input bit rdy);
        push_valid   = pv;
        push_id      = id;
        push_rd      = rd;
        push_we      = we;
        push_data    = data;
        commit_valid = cv;
        commit_kill  = ck;
        commit_id    = cid;
        result_ready = rdy;
    endtask

    // Advance the reference by one clock using the driven inputs, then move to the next falling edge.
    task automatic tick();
        bit   do_pop;
        bit   do_push;
        bit   k;
        ent_t e;
        do_pop  = (mq.size() > 0) && (mq[0].killed || result_ready);
        do_push = push_valid && (mq.size() < DEPTH);
        k       = commit_valid && commit_kill;
        if (k) begin
            foreach (mq[i]) if (mq[i].id == commit_id) mq[i].killed = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            e.id     = push_id;
            e.rd     = push_rd;
            e.we     = push_we;
            e.data   = push_data;
            e.killed = k && (push_id == commit_id);
            mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input bit pv, input int id, input bit cv, input bit ck, input int cid,
                       input bit rdy, input bit ev, input int eid, input int el, input bit ef);
        vec_t v;
        v.pv   = pv;
        v.id   = IDW'(id);
        v.rd   = 5'(id + 1);
        v.data = 32'hA500_0000 | 32'(id);
        v.cv   = cv;
        v.ck   = ck;
        v.cid  = IDW'(cid);
        v.rdy  = rdy;
        v.ev   = ev;
        v.eid  = IDW'(eid);
        v.el   = el;
        v.ef   = ef;
        vq.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, '0, 0, '0, 0, 0, '0, 0);
        #2;
        chk("reset valid", 64'(result_valid_o), 64'd0);
        chk("reset empty", 64'(empty_o), 64'd1);
        chk("reset level", 64'(level_o), 64'd0);
        chk("reset full", 64'(full_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset push_ready", 64'(push_ready_o), 64'd1);

        // Single push drained immediately
        add(1, 3, 0, 0, 0, 1,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,  1, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // Fill to full, rejected fifth push, ordered drain
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  1, 0, 1, 0);
        add(1, 2, 0, 0, 0, 0,  1, 0, 2, 0);
        add(1, 3, 0, 0, 0, 0,  1, 0, 3, 0);
        add(1, 4, 0, 0, 0, 0,  1, 0, 4, 1);
        add(0, 0, 0, 0, 0, 1,  1, 0, 4, 1);
        add(0, 0, 0, 0, 0, 1,  1, 1, 3, 0);
        add(0, 0, 0, 0, 0, 1,  1, 2, 2, 0);
        add(0, 0, 0, 0, 0, 1,  1, 3, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // Kill a middle entry; a commit without kill does nothing
        add(1, 5, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 6, 0, 0, 0, 0,  1, 5, 1, 0);
        add(1, 7, 0, 0, 0, 0,  1, 5, 2, 0);
        add(0, 0, 1, 0, 5, 0,  1, 5, 3, 0);
        add(0, 0, 1, 1, 6, 0,  1, 5, 3, 0);
        add(0, 0, 0, 0, 0, 1,  1, 5, 3, 0);
        add(0, 0, 0, 0, 0, 1,  0, 0, 2, 0);
        add(0, 0, 0, 0, 0, 1,  1, 7, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // Push and kill of the same id in one cycle
        add(1, 9, 1, 1, 9, 1,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // Full with simultaneous pop: push held off one cycle
        add(1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0,  1, 1, 1, 0);
        add(1, 3, 0, 0, 0, 0,  1, 1, 2, 0);
        add(1, 4, 0, 0, 0, 0,  1, 1, 3, 0);
        add(1, 5, 0, 0, 0, 1,  1, 1, 4, 1);
        add(1, 5, 0, 0, 0, 0,  1, 2, 3, 0);
        add(0, 0, 0, 0, 0, 1,  1, 2, 4, 1);
        add(0, 0, 0, 0, 0, 1,  1, 3, 3, 0);
        add(0, 0, 0, 0, 0, 1,  1, 4, 2, 0);
        add(0, 0, 0, 0, 0, 1,  1, 5, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vq[0].rd   = 5'd10;
        vq[0].data = 32'hDEAD_BEEF;

        for (int r = 0; r < vq.size(); r++) begin
            string tag;
            tag = $sformatf("vec%0d", r);
            chk({tag, " valid"}, 64'(result_valid_o), 64'(vq[r].ev));
            chk({tag, " id"}, 64'(result_id_o), vq[r].ev ? 64'(vq[r].eid) : 64'd0);
            chk({tag, " level"}, 64'(level_o), 64'(vq[r].el));
            chk({tag, " full"}, 64'(full_o), 64'(vq[r].ef));
            chk({tag, " empty"}, 64'(empty_o), 64'(vq[r].el == 0));
            chk({tag, " push_ready"}, 64'(push_ready_o), 64'(!vq[r].ef));
            if (r == 1) begin
                chk("vec1 rd", 64'(result_rd_o), 64'd10);
                chk("vec1 data", 64'(result_data_o), 64'hDEAD_BEEF);
            end
            check_model(tag);
            drive(vq[r].pv, vq[r].id, vq[r].rd, vq[r].id[0], vq[r].data,
                  vq[r].cv, vq[r].ck, vq[r].cid, vq[r].rdy);
            tick();
        end
        check_model("vec end");

        // Asynchronous reset with three entries queued
        for (int i = 1; i <= 3; i++) begin
            drive(1, IDW'(i), 5'(i), 1, 32'(i * 17), 0, 0, '0, 0);
            tick();
        end
        check_model("pre-reset");
        chk("pre-reset level", 64'(level_o), 64'd3);
        drive(0, '0, '0, 0, '0, 0, 0, '0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("async reset valid", 64'(result_valid_o), 64'd0);
        chk("async reset level", 64'(level_o), 64'd0);
        chk("async reset empty", 64'(empty_o), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-release empty", 64'(empty_o), 64'd1);
        chk("post-release level", 64'(level_o), 64'd0);
        check_model("post-release");

        // Randomized traffic against the reference queue
        for (int c = 0; c < 400; c++) begin
            check_model("rnd");
            drive(($urandom % 4) != 0, IDW'($urandom_range(0, 7)), 5'($urandom), 1'($urandom),
                  $urandom, ($urandom % 4) == 0, 1'($urandom), IDW'($urandom_range(0, 7)),
                  ($urandom % 3) != 0);
            tick();
        end
        check_model("rnd end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
